// File: rtl/tact_debouncer_pkg.sv
// Shared board-level constants and the debouncer state encoding.
package tact_debouncer_pkg;

   // Push-button polarity on the board: the pin reads low while pressed
   localparam logic TACT_ON  = 1'b0;
   localparam logic TACT_OFF = 1'b1;

   // Defaults for the 24 MHz board clock: 10 ms debounce, 1 s long press
   localparam int unsigned DEF_DB_CYCLES   = 240000;
   localparam int unsigned DEF_LONG_CYCLES = 24000000;

   typedef enum logic [2:0] {
      ST_RELEASED     = 3'd0,
      ST_PRESS_WAIT   = 3'd1,
      ST_PRESSED      = 3'd2,
      ST_HELD         = 3'd3,
      ST_RELEASE_WAIT = 3'd4
   } tact_state_e;

endpackage

// File: rtl/tact_debouncer_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous board input.
// The reset value is a parameter so idle-high and idle-low pins can share it.
module tact_debouncer_sync_2ff #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   // Shift the raw pin through two flops to settle metastability
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         meta_q <= RST_VAL;
         sync_q <= RST_VAL;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/tact_debouncer.sv
// Push-button conditioner: synchronises and debounces the active-low Tact1
// pin, provides a clean level of the same polarity plus press, release and
// long-press strobes. All outputs come straight from flops.
module tact_debouncer
   import tact_debouncer_pkg::*;
#(
   parameter int unsigned DB_CYCLES   = DEF_DB_CYCLES,
   parameter int unsigned W_DB        = 18,
   parameter int unsigned LONG_CYCLES = DEF_LONG_CYCLES,
   parameter int unsigned W_LONG      = 25
) (
   input  logic CLK_24MHz,
   input  logic RESET_N,
   input  logic TACT_IN,
   output logic TACT_LEVEL,
   output logic PRESS_PULSE,
   output logic RELEASE_PULSE,
   output logic LONG_PRESS,
   output logic HELD_LONG
);

   localparam logic [W_DB-1:0]   DB_LAST   = W_DB'(DB_CYCLES - 1);
   localparam logic [W_LONG-1:0] LONG_LAST = W_LONG'(LONG_CYCLES - 1);

   logic              s_tact;
   tact_state_e       state_q,    state_d;
   logic [W_DB-1:0]   db_cnt_q,   db_cnt_d;
   logic [W_LONG-1:0] hold_cnt_q, hold_cnt_d;
   logic              level_q,    level_d;
   logic              press_q,    press_d;
   logic              release_q,  release_d;
   logic              long_q,     long_d;
   logic              held_q,     held_d;

   tact_debouncer_sync_2ff #(
      .RST_VAL (TACT_OFF)
   ) u_sync (
      .clk_i  (CLK_24MHz),
      .rst_ni (RESET_N),
      .d_i    (TACT_IN),
      .q_o    (s_tact)
   );

   // State, counters and registered outputs
   always_ff @(posedge CLK_24MHz or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q    <= ST_RELEASED;
         db_cnt_q   <= '0;
         hold_cnt_q <= '0;
         level_q    <= TACT_OFF;
         press_q    <= 1'b0;
         release_q  <= 1'b0;
         long_q     <= 1'b0;
         held_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         db_cnt_q   <= db_cnt_d;
         hold_cnt_q <= hold_cnt_d;
         level_q    <= level_d;
         press_q    <= press_d;
         release_q  <= release_d;
         long_q     <= long_d;
         held_q     <= held_d;
      end
   end

   // Next state and counter updates; the hold count starts once the press
   // strobe has been seen, so LONG_PRESS trails PRESS_PULSE by LONG_CYCLES+1
   always_comb begin
      state_d    = state_q;
      db_cnt_d   = db_cnt_q;
      hold_cnt_d = hold_cnt_q;
      case (state_q)
         ST_RELEASED: begin
            if (s_tact == TACT_ON) begin
               state_d  = ST_PRESS_WAIT;
               db_cnt_d = '0;
            end
         end
         ST_PRESS_WAIT: begin
            if (s_tact == TACT_OFF) begin
               state_d = ST_RELEASED;
            end else if (db_cnt_q == DB_LAST) begin
               state_d    = ST_PRESSED;
               hold_cnt_d = '0;
            end else begin
               db_cnt_d = db_cnt_q + 1'b1;
            end
         end
         ST_PRESSED: begin
            if (s_tact == TACT_OFF) begin
               state_d  = ST_RELEASE_WAIT;
               db_cnt_d = '0;
            end else if (!press_q) begin
               if (hold_cnt_q == LONG_LAST) begin
                  state_d = ST_HELD;
               end else begin
                  hold_cnt_d = hold_cnt_q + 1'b1;
               end
            end
         end
         ST_HELD: begin
            if (s_tact == TACT_OFF) begin
               state_d  = ST_RELEASE_WAIT;
               db_cnt_d = '0;
            end
         end
         ST_RELEASE_WAIT: begin
            // A release glitch returns to the pressed side with the hold count kept
            if (s_tact == TACT_ON) begin
               state_d = held_q ? ST_HELD : ST_PRESSED;
            end else if (db_cnt_q == DB_LAST) begin
               state_d = ST_RELEASED;
            end else begin
               db_cnt_d = db_cnt_q + 1'b1;
            end
         end
         default: begin
            state_d    = ST_RELEASED;
            db_cnt_d   = '0;
            hold_cnt_d = '0;
         end
      endcase
   end

   // Next values of the registered outputs; strobes default low every cycle
   always_comb begin
      level_d   = level_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      long_d    = 1'b0;
      held_d    = held_q;
      case (state_q)
         ST_PRESS_WAIT: begin
            if ((s_tact == TACT_ON) && (db_cnt_q == DB_LAST)) begin
               level_d = TACT_ON;
               press_d = 1'b1;
            end
         end
         ST_PRESSED: begin
            if ((s_tact == TACT_ON) && !press_q && (hold_cnt_q == LONG_LAST)) begin
               long_d = 1'b1;
               held_d = 1'b1;
            end
         end
         ST_RELEASE_WAIT: begin
            if ((s_tact == TACT_OFF) && (db_cnt_q == DB_LAST)) begin
               level_d   = TACT_OFF;
               release_d = 1'b1;
               held_d    = 1'b0;
            end
         end
         ST_RELEASED, ST_HELD: begin
         end
         default: begin
            level_d = TACT_OFF;
            held_d  = 1'b0;
         end
      endcase
   end

   assign TACT_LEVEL    = level_q;
   assign PRESS_PULSE   = press_q;
   assign RELEASE_PULSE = release_q;
   assign LONG_PRESS    = long_q;
   assign HELD_LONG     = held_q;

endmodule

// File: tb/tb_tact_debouncer.sv
// Bench for tact_debouncer with shortened debounce and long-press timing.
module tb_tact_debouncer;

   localparam int DB   = 8;
   localparam int LONG = 32;
   // Negedge label of a strobe relative to the negedge where TACT_IN was driven
   localparam int LAT  = DB + 3;

   localparam logic [2:0] K_PRESS = 3'b001;
   localparam logic [2:0] K_REL   = 3'b010;
   localparam logic [2:0] K_LONG  = 3'b100;

   typedef struct {
      logic [2:0] kind;
      int         label;
      logic       level;
      logic       held;
   } ev_t;

   logic clk;
   logic RESET_N;
   logic TACT_IN;
   logic TACT_LEVEL;
   logic PRESS_PULSE;
   logic RELEASE_PULSE;
   logic LONG_PRESS;
   logic HELD_LONG;

   int  edge_n = 0;
   int  checks = 0;
   int  errors = 0;
   ev_t exp_q[$];
   ev_t mon_ev;
   int  mon_np;
   int  n;
   int  m;

   tact_debouncer #(
      .DB_CYCLES   (DB),
      .W_DB        (18),
      .LONG_CYCLES (LONG),
      .W_LONG      (25)
   ) dut (
      .CLK_24MHz     (clk),
      .RESET_N       (RESET_N),
      .TACT_IN       (TACT_IN),
      .TACT_LEVEL    (TACT_LEVEL),
      .PRESS_PULSE   (PRESS_PULSE),
      .RELEASE_PULSE (RELEASE_PULSE),
      .LONG_PRESS    (LONG_PRESS),
      .HELD_LONG     (HELD_LONG)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) edge_n <= edge_n + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic push_ev(input logic [2:0] k, input int lbl, input logic lv, input logic hd);
      ev_t e;
      e.kind  = k;
      e.label = lbl;
      e.level = lv;
      e.held  = hd;
      exp_q.push_back(e);
   endtask

   task automatic idle(input int k);
      repeat (k) @(negedge clk);
   endtask

   task automatic drive(input logic v, output int lbl);
      lbl     = edge_n;
      TACT_IN = v;
   endtask

   // Every strobe the DUT produces must match the next expected event
   always @(negedge clk) begin
      mon_np = 32'(PRESS_PULSE) + 32'(RELEASE_PULSE) + 32'(LONG_PRESS);
      if (mon_np != 0) begin
         chk("one_strobe", 32'(mon_np), 32'd1);
         if (exp_q.size() == 0) begin
            chk("unexpected_strobe", 32'({LONG_PRESS, RELEASE_PULSE, PRESS_PULSE}), 32'd0);
         end else begin
            mon_ev = exp_q.pop_front();
            chk("strobe_kind",  32'({LONG_PRESS, RELEASE_PULSE, PRESS_PULSE}), 32'(mon_ev.kind));
            chk("strobe_cycle", 32'(edge_n), 32'(mon_ev.label));
            chk("strobe_level", 32'(TACT_LEVEL), 32'(mon_ev.level));
            chk("strobe_held",  32'(HELD_LONG), 32'(mon_ev.held));
         end
      end
   end

   initial begin
      RESET_N = 1'b0;
      TACT_IN = 1'b0;

      // Reset held with the button pressed
      repeat (6) begin
         @(negedge clk);
         chk("rst_level",  32'(TACT_LEVEL), 32'd1);
         chk("rst_held",   32'(HELD_LONG), 32'd0);
         chk("rst_pulses", 32'({LONG_PRESS, RELEASE_PULSE, PRESS_PULSE}), 32'd0);
      end
      TACT_IN = 1'b1;
      @(negedge clk);
      RESET_N = 1'b1;
      idle(12);
      chk("idle_level", 32'(TACT_LEVEL), 32'd1);

      // Clean press and release
      drive(1'b0, n);
      push_ev(K_PRESS, n + LAT, 1'b0, 1'b0);
      idle(20);
      chk("press_level", 32'(TACT_LEVEL), 32'd0);
      drive(1'b1, m);
      push_ev(K_REL, m + LAT, 1'b1, 1'b0);
      idle(20);
      chk("clean_pending", 32'(exp_q.size()), 32'd0);
      chk("clean_level",   32'(TACT_LEVEL), 32'd1);

      // Bounce shorter than the debounce window
      drive(1'b0, n);
      idle(5);
      drive(1'b1, n);
      idle(3);
      drive(1'b0, n);
      idle(5);
      drive(1'b1, n);
      idle(20);
      chk("bounce_level",   32'(TACT_LEVEL), 32'd1);
      chk("bounce_pending", 32'(exp_q.size()), 32'd0);

      // Long press
      drive(1'b0, n);
      push_ev(K_PRESS, n + LAT, 1'b0, 1'b0);
      push_ev(K_LONG,  n + LAT + LONG + 1, 1'b0, 1'b1);
      idle(60);
      chk("long_held",  32'(HELD_LONG), 32'd1);
      chk("long_level", 32'(TACT_LEVEL), 32'd0);
      drive(1'b1, m);
      push_ev(K_REL, m + LAT, 1'b1, 1'b0);
      idle(20);
      chk("long_held_after", 32'(HELD_LONG), 32'd0);
      chk("long_pending",    32'(exp_q.size()), 32'd0);

      // Release glitch of 4 cycles: hold count pauses for glitch+1 edges, then resumes
      drive(1'b0, n);
      push_ev(K_PRESS, n + LAT, 1'b0, 1'b0);
      idle(15);
      drive(1'b1, m);
      idle(4);
      drive(1'b0, m);
      push_ev(K_LONG, n + LAT + LONG + 1 + 5, 1'b0, 1'b1);
      idle(6);
      chk("glitch_level", 32'(TACT_LEVEL), 32'd0);
      idle(34);
      chk("glitch_held", 32'(HELD_LONG), 32'd1);
      drive(1'b1, m);
      push_ev(K_REL, m + LAT, 1'b1, 1'b0);
      idle(20);
      chk("glitch_pending", 32'(exp_q.size()), 32'd0);

      // Asynchronous reset while hold_cnt is 20
      drive(1'b0, n);
      push_ev(K_PRESS, n + LAT, 1'b0, 1'b0);
      idle(32);
      chk("pre_rst_level", 32'(TACT_LEVEL), 32'd0);
      #2;
      RESET_N = 1'b0;
      #1;
      chk("arst_level",  32'(TACT_LEVEL), 32'd1);
      chk("arst_held",   32'(HELD_LONG), 32'd0);
      chk("arst_pulses", 32'({LONG_PRESS, RELEASE_PULSE, PRESS_PULSE}), 32'd0);
      idle(5);
      TACT_IN = 1'b1;
      idle(1);
      RESET_N = 1'b1;
      idle(50);
      chk("arst_pending", 32'(exp_q.size()), 32'd0);
      chk("arst_final_level", 32'(TACT_LEVEL), 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
